// File: rtl/ram_burst_pkg.sv
// Shared state encoding, default widths and response-buffer depth for the RAM burst initiator.
package ram_burst_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int RESP_DEPTH     = 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } burst_state_e;

endpackage

// File: rtl/ram_burst_resp_fifo.sv
// Two-entry read-response buffer carrying {data,last}; head is visible combinationally, one-cycle push-to-head latency.
// Caller must never push when full; the initiator's issue gate (count + inflight < depth) guarantees it.
module ram_burst_resp_fifo
  import ram_burst_pkg::*;
#(
  parameter int DW = DEF_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic [1:0]    count
);

  logic [DW-1:0] data_mem [RESP_DEPTH];
  logic          last_mem [RESP_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        data_mem[i] <= '0;
        last_mem[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= push_data;
        last_mem[wr_ptr] <= push_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = data_mem[rd_ptr];
  assign head_last = last_mem[rd_ptr];

endmodule

// File: rtl/ram_burst_initiator.sv
// Burst initiator for one RAM port: first request the cycle after command accept; reads buffered in a 2-entry FIFO.
// Response backpressure throttles read issue to 2 outstanding; RAM_BURST_STATS_EN adds beat/stall counters.
module ram_burst_initiator
  import ram_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  ram_valid,
  input  logic                  ram_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy,
  output logic                  done
`ifdef RAM_BURST_STATS_EN
  ,
  output logic [31:0]           stat_beats,
  output logic [31:0]           stat_stalls
`endif
);

  localparam logic [1:0] DEPTH = 2'(RESP_DEPTH);

  burst_state_e          state;
  burst_state_e          state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  done_q;
  logic [1:0]            fifo_count;
  logic                  fifo_pop;
  logic                  ram_xfer;
  logic                  last_beat;
  logic                  read_ok;

  assign ram_xfer    = ram_valid && ram_ready;
  assign last_beat   = (remain_q == '0);
  // In-flight read counts against the buffer so its result always has a slot.
  assign read_ok     = (fifo_count + {1'b0, inflight_q}) < DEPTH;
  assign rdata_valid = (fifo_count != 2'd0);
  assign fifo_pop    = rdata_valid && rdata_ready;
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign ram_addr    = addr_q;

  always_comb begin
    state_nxt   = state;
    ram_valid   = 1'b0;
    ram_we      = 1'b0;
    ram_data    = '0;
    wdata_ready = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = cmd_we ? WRITE : READ;
      end
      WRITE: begin
        ram_valid   = wdata_valid;
        ram_we      = 1'b1;
        ram_data    = wdata;
        wdata_ready = ram_ready;
        if (wdata_valid && ram_ready && last_beat) state_nxt = IDLE;
      end
      READ: begin
        ram_valid = read_ok;
        if (read_ok && ram_ready && last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fifo_count == 2'd0 && !inflight_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state           <= state_nxt;
      done_q          <= (state != IDLE) && (state_nxt == IDLE);
      inflight_q      <= ram_xfer && !ram_we;
      inflight_last_q <= last_beat;
      if (state == IDLE && cmd_valid) begin
        addr_q   <= cmd_addr;
        remain_q <= cmd_len;
      end else if (ram_xfer) begin
        addr_q   <= addr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
      end
    end
  end

  ram_burst_resp_fifo #(
    .DW(DATA_WIDTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_data(ram_q),
    .push_last(inflight_last_q),
    .pop      (fifo_pop),
    .head_data(rdata),
    .head_last(rdata_last),
    .count    (fifo_count)
  );

`ifdef RAM_BURST_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (ram_xfer && stat_beats != '1) stat_beats <= stat_beats + 32'd1;
      if (ram_valid && !ram_ready && stat_stalls != '1) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ram_burst_initiator.md
Name: ram_burst_initiator

Overview:
- Command-driven initiator for one port of the dual-port RAM; drives the port's addr/data/we/valid and consumes ready/q.
- Accepts one burst command at a time (read or write, base address, beat count).
- Write beats come in on a write-data stream; read beats go out on a response stream with full backpressure.
- Sits between a DMA/test sequencer and the RAM port; two instances (port A, port B) exercise the RAM concurrently.

Parameters:
ADDR_WIDTH, 8, RAM address width; burst address wraps modulo 2^ADDR_WIDTH
DATA_WIDTH, 8, RAM data width
LEN_WIDTH, 8, width of cmd_len; a burst is cmd_len+1 beats (1..2^LEN_WIDTH)

Ports:
clk  input  1  single clock for all logic
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  burst command valid
cmd_ready  output  1  high only in IDLE
cmd_we  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_WIDTH  base address
cmd_len  input  LEN_WIDTH  beats minus one
wdata_valid  input  1  write beat valid
wdata_ready  output  1  write beat accepted
wdata  input  DATA_WIDTH  write beat payload
rdata_valid  output  1  read beat valid
rdata_ready  input  1  downstream accepts read beat
rdata  output  DATA_WIDTH  read beat payload
rdata_last  output  1  marks final beat of read burst
ram_valid  output  1  RAM request valid
ram_ready  input  1  RAM accepts request
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_data  output  DATA_WIDTH  RAM write data
ram_q  input  DATA_WIDTH  RAM read data, valid the cycle after an accepted read
busy  output  1  high whenever not in IDLE
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async, rst_n low): state IDLE; cmd_ready=1; busy=0; done=0; ram_valid=0; ram_we=0; ram_addr=0; ram_data=0; wdata_ready=0; rdata_valid=0; rdata_last=0; beat counter, credit counter and response FIFO cleared. Reset mid-burst drops ram_valid immediately and abandons the burst; the in-flight read result is discarded.
- RAM handshake: a transfer occurs when ram_valid && ram_ready. While ram_valid && !ram_ready, ram_addr/ram_we/ram_data hold stable. ram_valid never depends on ram_ready.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: on cmd_valid, latch addr, len and we, then go to WRITE or READ. Zero-cycle gap from command to first ram_valid is not required; first request appears the cycle after acceptance.
- WRITE: ram_valid=wdata_valid; ram_we=1; ram_data=wdata; wdata_ready=ram_ready (combinational pass-through). Each RAM handshake increments the address (wrapping 0xFF->0x00 at default width) and decrements the remaining count. The last handshake moves the FSM to IDLE, with done=1 for that following cycle.
- READ: ram_we=0. A read is issued only when fifo_count + inflight < 2. The cycle after an accepted read, ram_q is pushed into the 2-entry response FIFO. After the last read handshake, move to DRAIN.
- DRAIN: wait until the FIFO is empty and nothing is in flight, then go to IDLE and pulse done.
- Response stream: rdata/rdata_last come from the FIFO head and hold while rdata_valid && !rdata_ready. rdata_last=1 only on beat cmd_len+1.
- rdata_ready held low indefinitely: at most 2 reads are outstanding and ram_valid stays low. No data is lost or reordered.
- Burst of 1 beat (cmd_len=0) is legal. Full 256-beat burst at default widths is legal.
- cmd_valid during a burst is ignored (cmd_ready=0).

Optional Feature:
- Macro RAM_BURST_STATS_EN.
- Defined: adds outputs stat_beats[31:0] and stat_stalls[31:0].
  - stat_beats counts RAM handshakes.
  - stat_stalls counts cycles with ram_valid && !ram_ready.
  - Both saturate at max and are cleared only by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ram_burst_pkg: state enum burst_state_e {IDLE, WRITE, READ, DRAIN}, default width localparams, and the RESP_DEPTH=2 constant.
- Sub-module ram_burst_resp_fifo: 2-entry FIFO with push/pop, count, and {data,last} payload. It is the only natural split.

Test Plan:
- Write burst addr=0x10, len=3, wdata 0xA0..0xA3, ram_ready=1 -> writes to 0x10..0x13 in 4 consecutive cycles; done pulse one cycle after the 4th handshake.
- Read back addr=0x10, len=3, rdata_ready=1 -> rdata 0xA0,0xA1,0xA2,0xA3; rdata_last only on 0xA3; done after last pop.
- Wrap: write addr=0xFE, len=3 -> addresses 0xFE,0xFF,0x00,0x01; readback matches.
- Backpressure: read len=7 with rdata_ready=0 for 10 cycles -> exactly 2 reads issued, ram_valid low afterwards; on release, all 8 beats arrive in order.
- RAM stall: ram_ready=0 for 5 cycles mid-write -> ram_addr/ram_data stable, wdata_ready=0; burst resumes without loss; with RAM_BURST_STATS_EN, stat_stalls=5.
- Reset mid-burst: assert rst_n low after 2 of 6 write beats -> ram_valid=0 immediately, cmd_ready=1 after release; a new len=0 write completes normally.
